// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-request load/store sequencer between the control
// unit and a strobe/ready memory bus. Load data is handed to the MDR with a
// one-cycle write-enable. Misaligned requests and bus timeouts are reported
// through error/err_code.
module mem_access_ctrl #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 15,
   parameter bit          ALIGN_CHECK    = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_rd,
   output logic                  mem_wr,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] mdr_data,
   output logic                  mdr_we,
   output logic                  done,
   output logic                  error,
   output logic [1:0]            err_code,
   output logic                  busy
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_COMPLETE,
      S_ERROR
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             wr_q;
   logic             misaligned;

   assign misaligned = ALIGN_CHECK && (req_addr[1:0] != 2'b00);

   // Ready only while idle and out of reset, so it rises as soon as reset releases.
   assign req_ready = reset_n && (state == S_IDLE);

   // Request sequencing FSM; every bus/MDR/status output is registered here.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         wait_cnt  <= '0;
         wr_q      <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mdr_data  <= '0;
         mdr_we    <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         err_code  <= 2'b00;
         busy      <= 1'b0;
      end else begin
         done   <= 1'b0;
         error  <= 1'b0;
         mdr_we <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  mem_addr  <= req_addr;
                  mem_wdata <= req_wdata;
                  wr_q      <= req_write;
                  wait_cnt  <= '0;
                  busy      <= 1'b1;
                  if (misaligned) begin
                     err_code <= 2'b01;
                     error    <= 1'b1;
                     state    <= S_ERROR;
                  end else begin
                     err_code <= 2'b00;
                     mem_rd   <= !req_write;
                     mem_wr   <= req_write;
                     state    <= S_ACCESS;
                  end
               end
            end
            S_ACCESS: begin
               // Timeout compares the pre-increment count, so ACCESS spans at
               // most TIMEOUT_CYCLES cycles and mem_ready on the last one wins.
               if (mem_ready) begin
                  mem_rd <= 1'b0;
                  mem_wr <= 1'b0;
                  done   <= 1'b1;
                  mdr_we <= !wr_q;
                  if (!wr_q) begin
                     mdr_data <= mem_rdata;
                  end
                  state <= S_COMPLETE;
               end else if (wait_cnt == CNT_LAST) begin
                  mem_rd   <= 1'b0;
                  mem_wr   <= 1'b0;
                  error    <= 1'b1;
                  err_code <= 2'b10;
                  state    <= S_ERROR;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_COMPLETE, S_ERROR: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               mem_rd <= 1'b0;
               mem_wr <= 1'b0;
               busy   <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized transaction stimulus with a transaction-level
// model that predicts every output cycle by cycle, plus directed literal checks.
module tb_mem_access_ctrl;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned T  = 15;

   logic          clk = 1'b0;
   logic          reset_n;

   logic          req_valid, req_write, req_ready;
   logic [AW-1:0] req_addr, mem_addr;
   logic [DW-1:0] req_wdata, mem_wdata, mem_rdata, mdr_data;
   logic          mem_rd, mem_wr, mem_ready, mdr_we, done, error, busy;
   logic [1:0]    err_code;

   logic          b_req_valid, b_req_write, b_req_ready;
   logic [AW-1:0] b_req_addr, b_mem_addr;
   logic [DW-1:0] b_req_wdata, b_mem_wdata, b_mem_rdata, b_mdr_data;
   logic          b_mem_rd, b_mem_wr, b_mem_ready, b_mdr_we, b_done, b_error, b_busy;
   logic [1:0]    b_err_code;

   always #5 clk = ~clk;

   mem_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T), .ALIGN_CHECK(1'b1)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .mdr_data(mdr_data), .mdr_we(mdr_we), .done(done), .error(error),
      .err_code(err_code), .busy(busy)
   );

   mem_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T), .ALIGN_CHECK(1'b0)) dut_noalign (
      .clk(clk), .reset_n(reset_n),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr),
      .mem_ready(b_mem_ready), .mem_rdata(b_mem_rdata),
      .mdr_data(b_mdr_data), .mdr_we(b_mdr_we), .done(b_done), .error(b_error),
      .err_code(b_err_code), .busy(b_busy)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int unsigned waits;
      int unsigned gap;
   } tx_t;

   typedef struct {
      logic        ready, bsy, rd, wr, dn, er, we;
      logic [31:0] addr, wdata, mdr;
      logic [1:0]  ec;
   } exp_t;

   exp_t        expq[$];
   tx_t         txs[$];
   logic [31:0] m_addr, m_wdata, m_mdr;
   logic [1:0]  m_err;
   int          n_checks = 0;
   int          n_pass   = 0;
   int          rd_cnt   = 0;
   int          wr_cnt   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic exp_t mk(input logic rdy, bsy, rd, wr, dn, er, we);
      exp_t e;
      e.ready = rdy; e.bsy = bsy; e.rd = rd; e.wr = wr;
      e.dn = dn; e.er = er; e.we = we;
      e.addr = m_addr; e.wdata = m_wdata; e.mdr = m_mdr; e.ec = m_err;
      return e;
   endfunction

   // Per-cycle comparison of the main DUT against the model's predictions.
   always @(negedge clk) begin
      exp_t e;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         chk("req_ready", 32'(req_ready), 32'(e.ready));
         chk("busy",      32'(busy),      32'(e.bsy));
         chk("mem_rd",    32'(mem_rd),    32'(e.rd));
         chk("mem_wr",    32'(mem_wr),    32'(e.wr));
         chk("done",      32'(done),      32'(e.dn));
         chk("error",     32'(error),     32'(e.er));
         chk("mdr_we",    32'(mdr_we),    32'(e.we));
         chk("mem_addr",  mem_addr,       e.addr);
         chk("mem_wdata", mem_wdata,      e.wdata);
         chk("mdr_data",  mdr_data,       e.mdr);
         chk("err_code",  32'(err_code),  32'(e.ec));
      end
   end

   // Strobe-cycle counters used by the directed literal checks.
   always @(negedge clk) begin
      if (mem_rd) rd_cnt++;
      if (mem_wr) wr_cnt++;
   end

   task automatic step(input exp_t e, input logic rv, rw, input logic [31:0] ra, rdat,
                       input logic mr, input logic [31:0] mrd);
      expq.push_back(e);
      req_valid = rv; req_write = rw; req_addr = ra; req_wdata = rdat;
      mem_ready = mr; mem_rdata = mrd;
      @(posedge clk);
      #1;
   endtask

   task automatic run_tx(input int i);
      tx_t         t;
      logic        hv, hw, ok, last;
      logic [31:0] ha, hd;
      int unsigned n;
      t  = txs[i];
      hv = 1'b0; hw = 1'($urandom); ha = $urandom; hd = $urandom;
      if (i + 1 < txs.size() && txs[i+1].gap == 0) begin
         hv = 1'b1; hw = txs[i+1].wr; ha = txs[i+1].addr; hd = txs[i+1].wdata;
      end
      repeat (t.gap)
         step(mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), 1'b0, 1'($urandom), $urandom, $urandom,
              1'($urandom), $urandom);
      step(mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), 1'b1, t.wr, t.addr, t.wdata,
           1'($urandom), $urandom);
      m_addr = t.addr; m_wdata = t.wdata; m_err = 2'b00;
      if (t.addr[1:0] != 2'b00) begin
         m_err = 2'b01;
         step(mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0), hv, hw, ha, hd, 1'($urandom), $urandom);
      end else begin
         ok = (t.waits < T);
         n  = ok ? t.waits + 1 : T;
         for (int unsigned j = 1; j <= n; j++) begin
            last = ok && (j == n);
            step(mk(1'b0,1'b1,!t.wr,t.wr,1'b0,1'b0,1'b0), hv, hw, ha, hd, last,
                 last ? t.rdata : $urandom);
         end
         if (ok) begin
            if (!t.wr) m_mdr = t.rdata;
            step(mk(1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,!t.wr), hv, hw, ha, hd, 1'($urandom), $urandom);
         end else begin
            m_err = 2'b10;
            step(mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0), hv, hw, ha, hd, 1'($urandom), $urandom);
         end
      end
   endtask

   function automatic tx_t dtx(input logic wr, input logic [31:0] addr, wdata, rdata,
                               input int unsigned waits, gap);
      tx_t t;
      t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdata = rdata; t.waits = waits; t.gap = gap;
      return t;
   endfunction

   initial begin
      int rb, wb;
      tx_t t;
      reset_n = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
      b_mem_ready = 1'b0; b_mem_rdata = '0;
      m_addr = '0; m_wdata = '0; m_mdr = '0; m_err = 2'b00;
      #1 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_strobes",   32'({mem_rd, mem_wr, done, error, mdr_we}), 32'd0);
      chk("rst_mem_addr",  mem_addr,  32'd0);
      chk("rst_mdr_data",  mdr_data,  32'd0);
      chk("rst_err_code",  32'(err_code), 32'd0);
      reset_n = 1'b1;
      #1;
      chk("rel_req_ready", 32'(req_ready), 32'd1);

      // Directed scenarios: zero-wait load, 3-wait store, misaligned, timeout,
      // ready on final allowed cycle, back-to-back queued store.
      txs.push_back(dtx(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, 0));
      txs.push_back(dtx(1'b1, 32'h0000_0040, 32'h1234_5678, 32'h5555_AAAA, 3, 0));
      txs.push_back(dtx(1'b0, 32'h0000_0006, 32'h0, 32'h1111_1111, 0, 1));
      txs.push_back(dtx(1'b0, 32'h0000_0020, 32'h0, 32'h2222_2222, T, 0));
      txs.push_back(dtx(1'b0, 32'h0000_0024, 32'h0, 32'hCAFE_F00D, T - 1, 0));
      txs.push_back(dtx(1'b1, 32'h0000_0028, 32'h7777_0000, 32'h3333_3333, 0, 0));

      rb = rd_cnt; wb = wr_cnt; run_tx(0);
      chk("t0_rd_cycles", 32'(rd_cnt - rb), 32'd1);
      chk("t0_mdr_data",  mdr_data, 32'hDEAD_BEEF);
      chk("t0_err_code",  32'(err_code), 32'd0);
      rb = rd_cnt; wb = wr_cnt; run_tx(1);
      chk("t1_wr_cycles", 32'(wr_cnt - wb), 32'd4);
      chk("t1_rd_cycles", 32'(rd_cnt - rb), 32'd0);
      chk("t1_mem_wdata", mem_wdata, 32'h1234_5678);
      chk("t1_mdr_hold",  mdr_data, 32'hDEAD_BEEF);
      rb = rd_cnt; wb = wr_cnt; run_tx(2);
      chk("t2_strobes",   32'((rd_cnt - rb) + (wr_cnt - wb)), 32'd0);
      chk("t2_err_code",  32'(err_code), 32'd1);
      rb = rd_cnt; run_tx(3);
      chk("t3_rd_cycles", 32'(rd_cnt - rb), 32'd15);
      chk("t3_err_code",  32'(err_code), 32'd2);
      chk("t3_mdr_hold",  mdr_data, 32'hDEAD_BEEF);
      rb = rd_cnt; run_tx(4);
      chk("t4_rd_cycles", 32'(rd_cnt - rb), 32'd15);
      chk("t4_err_code",  32'(err_code), 32'd0);
      chk("t4_mdr_data",  mdr_data, 32'hCAFE_F00D);
      run_tx(5);

      // Asynchronous reset in the second wait cycle of a load.
      step(mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, $urandom);
      m_addr = 32'h80; m_wdata = 32'h0; m_err = 2'b00;
      step(mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0), 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, $urandom);
      reset_n = 1'b0;
      #1;
      chk("ar_strobes",  32'({mem_rd, mem_wr}), 32'd0);
      chk("ar_pulses",   32'({done, error, mdr_we}), 32'd0);
      chk("ar_busy",     32'({busy, req_ready}), 32'd0);
      chk("ar_mem_addr", mem_addr, 32'd0);
      chk("ar_mdr_data", mdr_data, 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      m_addr = '0; m_wdata = '0; m_mdr = '0; m_err = 2'b00;
      #1;
      chk("ar_rel_ready", 32'(req_ready), 32'd1);

      // Randomized traffic, opened by a zero-wait load after the reset.
      txs.delete();
      txs.push_back(dtx(1'b0, 32'h0000_0100, 32'h0, 32'hA5A5_5A5A, 0, 0));
      for (int k = 0; k < 300; k++) begin
         t.wr    = 1'($urandom);
         t.addr  = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 5) == 0) t.addr[1:0] = 2'($urandom_range(1, 3));
         t.wdata = $urandom;
         t.rdata = $urandom;
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: t.waits = $urandom_range(0, 3);
            6, 7:             t.waits = $urandom_range(4, 13);
            8:                t.waits = T - 1;
            default:          t.waits = T;
         endcase
         t.gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 2);
         txs.push_back(t);
      end
      run_tx(0);
      chk("pr_mdr_data", mdr_data, 32'hA5A5_5A5A);
      for (int k = 1; k < txs.size(); k++) run_tx(k);

      // ALIGN_CHECK=0 instance: a misaligned load runs a normal bus access.
      req_valid = 1'b0;
      b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'h0000_0006; b_req_wdata = 32'h0;
      @(posedge clk); #1;
      b_req_valid = 1'b0; b_mem_ready = 1'b1; b_mem_rdata = 32'h0BAD_F00D;
      chk("na_mem_rd",   32'(b_mem_rd), 32'd1);
      chk("na_mem_addr", b_mem_addr, 32'h0000_0006);
      @(posedge clk); #1;
      b_mem_ready = 1'b0;
      chk("na_done",     32'({b_done, b_mdr_we, b_error}), 32'b110);
      chk("na_mdr_data", b_mdr_data, 32'h0BAD_F00D);
      chk("na_err_code", 32'(b_err_code), 32'd0);
      @(posedge clk); #1;
      chk("na_ready",    32'({b_req_ready, b_busy}), 32'b10);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Bus-side sequencer sitting directly upstream of the memory data register. Accepts one load/store request at a time from the control unit and drives a simple strobe/ready memory bus with wait states. On load completion it hands the read word to the MDR as a data word plus a one-cycle write-enable pulse. Flags misaligned addresses and bus timeouts.

Parameters:
ADDR_WIDTH, 32, width of request and memory addresses
DATA_WIDTH, 32, data word width; fixed at 32, so word = 4 bytes
TIMEOUT_CYCLES, 15, maximum ACCESS-state cycles without mem_ready before a timeout error; must be >= 1
ALIGN_CHECK, 1, 1 = reject requests whose addr[1:0] != 0; 0 = pass all addresses

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  control unit presents a request
req_ready  out  1  block can accept; high only in IDLE
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  store data
mem_addr  out  ADDR_WIDTH  registered bus address
mem_wdata  out  DATA_WIDTH  registered bus write data
mem_rd  out  1  read strobe
mem_wr  out  1  write strobe
mem_ready  in  1  bus completes the current access this cycle
mem_rdata  in  DATA_WIDTH  bus read data; valid when mem_ready=1
mdr_data  out  DATA_WIDTH  word to the MDR data_in
mdr_we  out  1  one-cycle write-enable to the MDR
done  out  1  one-cycle pulse: request completed OK
error  out  1  one-cycle pulse: request aborted
err_code  out  2  01 = misaligned, 10 = timeout, 00 = none; held until next accept
busy  out  1  state != IDLE

Behaviour:
- Clocking/reset: one clock, clk; reset_n is asynchronous and active-low. In reset, state=IDLE, all outputs 0, including mem_addr, mem_wdata, mdr_data and err_code. req_ready becomes 1 on reset release.
- States: IDLE, ACCESS, COMPLETE, ERROR. One-hot or binary encoding is free; unused encodings go to IDLE.
- IDLE: req_ready=1. Accept occurs at an edge where req_valid=1.
  - On accept: latch req_addr into mem_addr, req_wdata into mem_wdata and req_write internally; clear err_code; clear the wait counter.
  - If ALIGN_CHECK=1 and req_addr[1:0]!=0, go to ERROR with err_code=01. No bus strobe is ever raised.
  - Otherwise go to ACCESS.
- ACCESS:
  - mem_rd = !write and mem_wr = write, both held steady; mem_addr and mem_wdata are stable for the whole state.
  - mem_ready=1 at an edge: for a load, capture mem_rdata into mdr_data; go to COMPLETE.
  - mem_ready=0: increment the wait counter. If the counter equals TIMEOUT_CYCLES-1, go to ERROR with err_code=10.
  - ACCESS therefore lasts at most TIMEOUT_CYCLES cycles. mem_ready on the final allowed cycle wins over timeout.
- COMPLETE: lasts one cycle. done=1; mdr_we=1 for loads only (0 for stores). Strobes are low. Then go to IDLE.
- ERROR: lasts one cycle. error=1; strobes low; mdr_we=0 and mdr_data unchanged. Then go to IDLE.
- Latency from the accepting edge:
  - Zero-wait load: mem_rd high in cycle 1; done and mdr_we high in cycle 2; req_ready high again in cycle 3.
  - Each wait cycle adds one cycle.
- No back-to-back accept: req_valid is ignored outside IDLE, and the request must stay held until accepted.
- mdr_data changes only on a successful load capture; it holds otherwise.
- mem_ready outside ACCESS is ignored.
- Asynchronous reset mid-ACCESS: strobes drop immediately and the transaction is abandoned; no done, error or mdr_we.
- Wait counter width is clog2(TIMEOUT_CYCLES)+1, with no wrap inside ACCESS.

Test Plan:
- Load, addr=0x0000_0010, mem_ready high in the first ACCESS cycle, mem_rdata=0xDEAD_BEEF -> mem_rd for exactly 1 cycle; mdr_data=0xDEAD_BEEF with mdr_we and done pulsing 2 cycles after accept; err_code=00.
- Store, addr=0x40, wdata=0x1234_5678, mem_ready after 3 wait cycles -> mem_wr high 4 cycles with mem_addr=0x40 and mem_wdata=0x1234_5678 stable; done pulse; mdr_we stays 0; mdr_data unchanged.
- Load, addr=0x0000_0006 with ALIGN_CHECK=1 -> mem_rd/mem_wr never high; error pulse 1 cycle after accept; err_code=01. Repeat with ALIGN_CHECK=0 -> normal bus access.
- Load with mem_ready held 0 and TIMEOUT_CYCLES=15 -> mem_rd high exactly 15 cycles; error pulse; err_code=10; mdr_we=0. Variant with mem_ready on the 15th cycle -> done, no error.
- reset_n driven low during the 2nd wait cycle of a load -> strobes and outputs go to 0 asynchronously; after release req_ready=1 and a new zero-wait load completes normally.
- req_valid held high across two queued requests -> second accept occurs only in IDLE, one cycle after the first done; busy deasserts only in IDLE.
